// File: rtl/ysyx_24100012_ifu_queue_if.sv
// Fetch-side bundle of the IFU queue: redirect, memory request/response and instruction output.
// The master modport is the IFU; the slave modport is its environment (memory plus consumer).
interface ysyx_24100012_ifu_queue_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_inst;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  halted;

  modport master (
    input  redirect_valid, redirect_pc, req_ready, rsp_valid, rsp_data, out_ready,
    output req_valid, req_addr, out_valid, out_inst, out_pc, halted
  );

  modport slave (
    output redirect_valid, redirect_pc, req_ready, rsp_valid, rsp_data, out_ready,
    input  req_valid, req_addr, out_valid, out_inst, out_pc, halted
  );
endinterface

// File: rtl/ysyx_24100012_ifu_queue.sv
// Instruction fetch unit: one outstanding memory fetch at a time feeding a small {pc, inst} queue.
// Fetch stops once an ebreak is queued; popping it freezes the unit until reset.
module ysyx_24100012_ifu_queue #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] ORIGIN_ADDR = 32'h80000000,
  parameter int unsigned           DEPTH       = 4,
  parameter int unsigned           WORD_SIZE   = 4
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_24100012_ifu_queue_if.master io_bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] EBREAK = DATA_WIDTH'(32'h00100073);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      r_rptr;
  logic [PTR_W-1:0]      r_wptr;
  logic                  r_halt_pending;
  logic [DATA_WIDTH-1:0] r_inst [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc   [DEPTH];

  logic                  w_redirect;
  logic                  w_req_valid;
  logic                  w_req_fire;
  logic                  w_out_valid;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_pop_ebreak;
  logic [DATA_WIDTH-1:0] w_head_inst;
  logic [1:0]            w_state_next;
  logic [CNT_W-1:0]      w_count_next;

  // HALT is terminal, so a redirect there must not disturb anything.
  assign w_redirect   = io_bus.redirect_valid && (r_state != S_HALT);
  assign w_req_valid  = (r_state == S_IDLE) && (r_count < CNT_W'(DEPTH)) && !r_halt_pending &&
                        !io_bus.redirect_valid;
  assign w_req_fire   = w_req_valid && io_bus.req_ready;
  assign w_out_valid  = (r_count != '0) && (r_state != S_HALT);
  assign w_push       = (r_state == S_WAIT) && io_bus.rsp_valid && !w_redirect;
  assign w_pop        = w_out_valid && io_bus.out_ready && !w_redirect;
  assign w_head_inst  = r_inst[r_rptr];
  assign w_pop_ebreak = w_pop && (w_head_inst == EBREAK);

  assign io_bus.req_valid = w_req_valid;
  assign io_bus.req_addr  = r_fetch_pc;
  assign io_bus.out_valid = w_out_valid;
  assign io_bus.out_inst  = w_head_inst;
  assign io_bus.out_pc    = r_pc[r_rptr];
  assign io_bus.halted    = (r_state == S_HALT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_fire) w_state_next = S_WAIT;
      // A redirect racing the response simply drops it; otherwise the reply is still owed.
      S_WAIT: begin
        if (io_bus.rsp_valid)  w_state_next = S_IDLE;
        else if (w_redirect)   w_state_next = S_DRAIN;
      end
      S_DRAIN: if (io_bus.rsp_valid) w_state_next = S_IDLE;
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase
    if (w_pop_ebreak) w_state_next = S_HALT;
  end

  always_comb begin
    w_count_next = r_count;
    if (w_redirect) begin
      w_count_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + CNT_W'(1);
        2'b01:   w_count_next = r_count - CNT_W'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_fetch_pc     <= ORIGIN_ADDR;
      r_req_pc       <= ORIGIN_ADDR;
      r_count        <= '0;
      r_rptr         <= '0;
      r_wptr         <= '0;
      r_halt_pending <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_redirect) begin
        r_fetch_pc <= io_bus.redirect_pc;
      end else if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(WORD_SIZE);
      end
      if (w_req_fire) r_req_pc <= r_fetch_pc;
      if (w_redirect) begin
        r_rptr <= '0;
        r_wptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_redirect) begin
        r_halt_pending <= 1'b0;
      end else if (w_push && (io_bus.rsp_data == EBREAK)) begin
        r_halt_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst[r_wptr] <= io_bus.rsp_data;
      r_pc[r_wptr]   <= r_req_pc;
    end
  end
endmodule

// File: tb/tb_ysyx_24100012_ifu_queue.sv
// Randomised bench for the IFU queue: a queue-based fetch model feeds a scoreboard that a
// separate monitor drains whenever the DUT hands out an instruction.
module tb_ysyx_24100012_ifu_queue;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] ORIGIN = 32'h80000000;
  localparam logic [31:0] EBREAK = 32'h00100073;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_24100012_ifu_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ysyx_24100012_ifu_queue #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ORIGIN_ADDR(ORIGIN),
    .DEPTH      (DEPTH),
    .WORD_SIZE  (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Stimulus knobs (percentages) changed by the main sequence mid-cycle.
  int          p_req     = 100;
  int          p_out     = 0;
  int          p_redir   = 0;
  int          p_spur    = 0;
  int          max_delay = 0;
  bit          ebreak_en = 1'b0;
  logic [31:0] ebreak_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] d;
    if (ebreak_en && addr == ebreak_addr) return EBREAK;
    d = $urandom;
    if (d == EBREAK) d = 32'h00000013;
    return d;
  endfunction

  // Reference model state: what the fetch unit should hold, in plain terms.
  entry_t      exp_q[$];
  logic [31:0] m_pc           = ORIGIN;
  logic [31:0] m_req_pc       = ORIGIN;
  bit          m_outstanding  = 1'b0;
  bit          m_stale        = 1'b0;
  bit          m_halt_pending = 1'b0;
  bit          m_halted       = 1'b0;

  // Driver and memory: inputs change only on the falling edge.
  initial begin : drv
    bit          mem_busy;
    int          mem_delay;
    logic [31:0] mem_addr;
    mem_busy = 1'b0;
    mem_delay = 0;
    mem_addr = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.req_ready      = 1'b0;
    bus.rsp_valid      = 1'b0;
    bus.rsp_data       = '0;
    bus.out_ready      = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_busy = 1'b0;
        bus.rsp_valid = 1'b0;
      end else if (mem_busy && mem_delay == 0) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = mem_word(mem_addr);
        mem_busy = 1'b0;
      end else begin
        if (mem_busy) mem_delay--;
        bus.rsp_valid = !mem_busy && ($urandom_range(0, 99) < p_spur);
        bus.rsp_data  = mem_word(32'hffff_fff0);
      end
      bus.req_ready      = $urandom_range(0, 99) < p_req;
      bus.out_ready      = $urandom_range(0, 99) < p_out;
      bus.redirect_valid = $urandom_range(0, 99) < p_redir;
      bus.redirect_pc    = ORIGIN + 32'h100 + ($urandom_range(0, 255) << 2);
      #2;
      if (!rst && bus.req_valid && bus.req_ready) begin
        mem_busy  = 1'b1;
        mem_delay = $urandom_range(0, max_delay);
        mem_addr  = bus.req_addr;
      end
    end
  end

  // Model: checks the request side, then applies the edge's effects just after it.
  initial begin : model
    bit          rst_s, red, exp_req, fire, rsp;
    logic [31:0] rpc, rdata;
    entry_t      e;
    forever begin
      @(negedge clk);
      #3;
      rst_s   = rst;
      red     = bus.redirect_valid && !m_halted;
      rpc     = bus.redirect_pc;
      rdata   = bus.rsp_data;
      exp_req = !m_halted && !m_outstanding && !m_halt_pending && (exp_q.size() < DEPTH) &&
                !bus.redirect_valid;
      fire = 1'b0;
      rsp  = 1'b0;
      if (!rst_s) begin
        check("req_valid", bus.req_valid, exp_req);
        if (exp_req) check("req_addr", bus.req_addr, m_pc);
        fire = exp_req && bus.req_ready;
        rsp  = bus.rsp_valid && m_outstanding && !m_halted;
      end
      @(posedge clk);
      #1;
      if (rst_s) begin
        exp_q.delete();
        m_pc = ORIGIN;
        m_outstanding = 1'b0;
        m_stale = 1'b0;
        m_halt_pending = 1'b0;
        m_halted = 1'b0;
      end else begin
        if (red) begin
          exp_q.delete();
          m_halt_pending = 1'b0;
          m_pc = rpc;
          if (rsp) begin
            m_outstanding = 1'b0;
            m_stale = 1'b0;
          end else if (m_outstanding) begin
            m_stale = 1'b1;
          end
        end else if (rsp) begin
          if (!m_stale) begin
            e.pc = m_req_pc;
            e.inst = rdata;
            exp_q.push_back(e);
            if (rdata == EBREAK) m_halt_pending = 1'b1;
          end
          m_outstanding = 1'b0;
          m_stale = 1'b0;
        end
        if (fire) begin
          m_outstanding = 1'b1;
          m_stale = 1'b0;
          m_req_pc = m_pc;
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the consumer takes an instruction.
  initial begin : mon
    entry_t head;
    bit     exp_valid;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        exp_valid = (exp_q.size() != 0) && !m_halted;
        check("halted", bus.halted, m_halted);
        check("out_valid", bus.out_valid, exp_valid);
        if (exp_valid && bus.out_ready && !bus.redirect_valid) begin
          head = exp_q.pop_front();
          check("out_pc", bus.out_pc, head.pc);
          check("out_inst", bus.out_inst, head.inst);
          if (head.inst == EBREAK) m_halted = 1'b1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #6;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_req_valid", bus.req_valid, 1'b1);
    check("rst_req_addr", bus.req_addr, ORIGIN);
    check("rst_halted", bus.halted, 1'b0);
    #5;
  endtask

  initial begin : main
    // Sequential fetch with a 1-cycle memory and an always-ready consumer.
    p_req = 100; p_out = 100; p_redir = 0; p_spur = 0; max_delay = 0;
    do_reset();
    step(40);

    // Mixed random traffic with slow memory, redirects and stray responses.
    p_req = 70; p_out = 60; p_redir = 5; p_spur = 5; max_delay = 3;
    step(3000);

    // Fast memory with frequent redirects, hitting redirect/response/pop collisions.
    p_req = 90; p_out = 80; p_redir = 15; p_spur = 0; max_delay = 0;
    step(1000);

    // Stalled consumer: the queue fills, then a single pop admits one more fetch.
    p_req = 100; p_out = 0; p_redir = 0; p_spur = 0; max_delay = 0;
    do_reset();
    step(20);
    check("full_req_valid", bus.req_valid, 1'b0);
    check("full_out_valid", bus.out_valid, 1'b1);
    p_out = 100;
    step(1);
    p_out = 0;
    step(10);
    check("refill_req_valid", bus.req_valid, 1'b0);

    // Ebreak at the third word: fetch stops, popping it halts until reset.
    p_req = 100; p_out = 50; p_redir = 0; max_delay = 0;
    ebreak_en = 1'b1; ebreak_addr = ORIGIN + 32'd8;
    do_reset();
    for (int i = 0; i < 200 && !bus.halted; i++) @(negedge clk);
    #1;
    check("halt_reached", bus.halted, 1'b1);
    p_redir = 50; p_out = 100;
    step(30);
    check("halt_hold", bus.halted, 1'b1);
    check("halt_out_valid", bus.out_valid, 1'b0);
    check("halt_req_valid", bus.req_valid, 1'b0);

    // Reset leaves HALT; finish with more random traffic.
    ebreak_en = 1'b0;
    p_req = 80; p_out = 70; p_redir = 0; p_spur = 5; max_delay = 2;
    do_reset();
    p_redir = 5;
    step(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
